// File: rtl/traffic_mode_fsm_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic mode arbiter and the per-mode light
// sequencers that consume its mode output.
//   mode_e         : 2-bit mode encoding (DAY, NIGHT, PED, EMG)
//   MODE_RESET     : mode taken out of reset
//   day_night_mode : maps a debounced day flag onto DAY/NIGHT
// ---------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    MODE_DAY   = 2'b00,
    MODE_NIGHT = 2'b01,
    MODE_PED   = 2'b10,
    MODE_EMG   = 2'b11
  } mode_e;

  localparam mode_e MODE_RESET = MODE_NIGHT;

  function automatic mode_e day_night_mode(input logic day);
    return day ? MODE_DAY : MODE_NIGHT;
  endfunction

endpackage

// File: rtl/traffic_mode_fsm_if.sv
// ---------------------------------------------------------------------------
// traffic_mode_fsm_if
// Request inputs and mode outputs of the traffic mode arbiter.
//   timeSignal   : raw day(1)/night(0) sensor
//   pedSignal    : pedestrian request, level or pulse
//   emgSignal    : emergency vehicle present, level
//   currentState : registered mode
//   modeChanged  : pulse in the first cycle a new mode is visible
//   pedAck       : pulse on entry to PED
//   dwellCount   : saturating cycles spent in the current mode
// master = request source / monitor side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface traffic_mode_fsm_if #(
  parameter int DWELL_W = 8
);
  import traffic_pkg::*;

  logic               timeSignal;
  logic               pedSignal;
  logic               emgSignal;
  mode_e              currentState;
  logic               modeChanged;
  logic               pedAck;
  logic [DWELL_W-1:0] dwellCount;

  modport master (
    output timeSignal, pedSignal, emgSignal,
    input  currentState, modeChanged, pedAck, dwellCount
  );

  modport slave (
    input  timeSignal, pedSignal, emgSignal,
    output currentState, modeChanged, pedAck, dwellCount
  );

endinterface

// File: rtl/traffic_mode_fsm_sig_debounce.sv
// ---------------------------------------------------------------------------
// sig_debounce
// Single-bit level debouncer. The output follows the raw input only after
// DEBOUNCE consecutive samples that all differ from the current output; a
// sample equal to the output restarts the count.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (output -> RESET_VAL)
//   raw_i : raw input
//   deb_o : debounced, registered level
// CNT_W must be wide enough to hold DEBOUNCE-1.
// ---------------------------------------------------------------------------
module sig_debounce #(
  parameter int   DEBOUNCE  = 4,
  parameter int   CNT_W     = 8,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic deb_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             deb_q;
  logic [CNT_W-1:0] cnt_q;

  // cnt_q counts differing samples already seen; the DEBOUNCE-th one flips
  // the output, so a change stable from edge k is accepted at edge
  // k+DEBOUNCE-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= RESET_VAL;
      cnt_q <= '0;
    end else if (raw_i == deb_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_q <= raw_i;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/traffic_mode_fsm.sv
// ---------------------------------------------------------------------------
// traffic_mode_fsm
// Arbitrates day/night, pedestrian and emergency requests into one
// registered mode (priority EMG > PED > DAY/NIGHT) with a minimum dwell in
// DAY/NIGHT, a timed PED crossing and an EMG clear-out hold.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : traffic_mode_fsm_if.slave (requests in, mode/status out)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module traffic_mode_fsm
  import traffic_pkg::*;
#(
  parameter int DWELL_W   = 8,
  parameter int MIN_DWELL = 16,
  parameter int PED_TIME  = 32,
  parameter int EMG_CLEAR = 8,
  parameter int DEBOUNCE  = 4
) (
  input logic                clk,
  input logic                rst,
  traffic_mode_fsm_if.slave  bus
);

  localparam logic [DWELL_W-1:0] MIN_DWELL_C = DWELL_W'(MIN_DWELL);
  localparam logic [DWELL_W-1:0] PED_LAST_C  = DWELL_W'(PED_TIME - 1);
  localparam logic [DWELL_W-1:0] EMG_CLEAR_C = DWELL_W'(EMG_CLEAR);

  mode_e              mode_q, mode_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] clr_q, clr_d;
  logic               ped_pend_q, ped_pend_d;
  logic               mode_changed_q;
  logic               ped_ack_q;

  logic  deb_time;
  logic  ped_req;
  logic  dwell_ok;
  logic  mode_chg;
  logic  ped_entry;
  mode_e dn_target;

  sig_debounce #(
    .DEBOUNCE  (DEBOUNCE),
    .CNT_W     (DWELL_W),
    .RESET_VAL (1'b0)
  ) u_time_deb (
    .clk   (clk),
    .rst   (rst),
    .raw_i (bus.timeSignal),
    .deb_o (deb_time)
  );

  always_comb begin
    mode_d    = mode_q;
    clr_d     = clr_q;
    // A request sampled this edge counts immediately and is also
    // remembered, so a single-cycle pulse is never dropped.
    ped_req    = ped_pend_q | bus.pedSignal;
    ped_pend_d = ped_req;
    dwell_ok   = (dwell_q >= MIN_DWELL_C);
    dn_target  = day_night_mode(deb_time);

    case (mode_q)
      MODE_DAY, MODE_NIGHT: begin
        if (bus.emgSignal) begin
          mode_d = MODE_EMG;
          clr_d  = EMG_CLEAR_C;
        end else if (ped_req && dwell_ok) begin
          mode_d = MODE_PED;
        end else if ((dn_target != mode_q) && dwell_ok) begin
          mode_d = dn_target;
        end
      end
      MODE_PED: begin
        if (bus.emgSignal) begin
          // Aborted crossing is re-queued.
          mode_d     = MODE_EMG;
          clr_d      = EMG_CLEAR_C;
          ped_pend_d = 1'b1;
        end else if (dwell_q == PED_LAST_C) begin
          mode_d = dn_target;
        end
      end
      MODE_EMG: begin
        if (bus.emgSignal) begin
          clr_d = EMG_CLEAR_C;
        end else if (clr_q == '0) begin
          // Never exits straight to PED; a pending request waits for dwell.
          mode_d = dn_target;
        end else begin
          clr_d = clr_q - 1'b1;
        end
      end
      default: mode_d = MODE_RESET;
    endcase

    ped_entry = (mode_d == MODE_PED) && (mode_q != MODE_PED);
    if (ped_entry) begin
      ped_pend_d = 1'b0;
    end

    mode_chg = (mode_d != mode_q);
    if (mode_chg) begin
      dwell_d = '0;
    end else if (dwell_q == '1) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q         <= MODE_RESET;
      dwell_q        <= '0;
      clr_q          <= '0;
      ped_pend_q     <= 1'b0;
      mode_changed_q <= 1'b0;
      ped_ack_q      <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      dwell_q        <= dwell_d;
      clr_q          <= clr_d;
      ped_pend_q     <= ped_pend_d;
      mode_changed_q <= mode_chg;
      ped_ack_q      <= ped_entry;
    end
  end

  assign bus.currentState = mode_q;
  assign bus.modeChanged  = mode_changed_q;
  assign bus.pedAck       = ped_ack_q;
  assign bus.dwellCount   = dwell_q;

endmodule

// File: tb/tb_traffic_mode_fsm.sv
// ---------------------------------------------------------------------------
// tb_traffic_mode_fsm
// Directed table of {inputs held for N edges, expected outputs} records,
// plus a hand-written asynchronous mid-PED reset sequence.
// ---------------------------------------------------------------------------
module tb_traffic_mode_fsm;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  traffic_mode_fsm_if #(.DWELL_W(8)) bus ();

  traffic_mode_fsm #(
    .DWELL_W   (8),
    .MIN_DWELL (16),
    .PED_TIME  (32),
    .EMG_CLEAR (8),
    .DEBOUNCE  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic  t;
    logic  p;
    logic  e;
    int    n;
    mode_e st;
    logic  mc;
    logic  ack;
    int    dw;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(input logic t, input logic p, input logic e,
                              input int n, input mode_e st, input logic mc,
                              input logic ack, input int dw);
    vec_t v;
    v.t = t; v.p = p; v.e = e; v.n = n;
    v.st = st; v.mc = mc; v.ack = ack; v.dw = dw;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input mode_e st, input logic mc,
                               input logic ack, input int dw);
    check({tag, ".state"}, int'(bus.currentState), int'(st));
    check({tag, ".modeChanged"}, int'(bus.modeChanged), int'(mc));
    check({tag, ".pedAck"}, int'(bus.pedAck), int'(ack));
    check({tag, ".dwell"}, int'(bus.dwellCount), dw);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_seen;

    // Stimulus table: inputs applied at a negedge, held for n edges, then checked.
    add(1,0,0, 16, MODE_NIGHT,0,0,16);  // dwell not yet met
    add(1,0,0,  1, MODE_DAY,  1,0, 0);  // switch at dwell 16
    add(1,0,0,  1, MODE_DAY,  0,0, 1);  // modeChanged one cycle only
    add(1,0,0, 39, MODE_DAY,  0,0,40);
    add(1,1,0,  1, MODE_PED,  1,1, 0);  // pulse at dwell 40
    add(1,0,0,  1, MODE_PED,  0,0, 1);  // pedAck one cycle only
    add(1,0,0, 30, MODE_PED,  0,0,31);
    add(1,0,0,  1, MODE_DAY,  1,0, 0);  // PED lasted 32 cycles
    add(1,0,0,  3, MODE_DAY,  0,0, 3);
    add(1,1,0,  1, MODE_DAY,  0,0, 4);  // early pulse is remembered
    add(1,0,0, 12, MODE_DAY,  0,0,16);
    add(1,0,0,  1, MODE_PED,  1,1, 0);
    add(1,0,0, 10, MODE_PED,  0,0,10);
    add(1,0,1,  1, MODE_EMG,  1,0, 0);  // preempt crossing
    add(1,0,1,  4, MODE_EMG,  0,0, 4);
    add(1,0,0,  8, MODE_EMG,  0,0,12);  // clear-out hold
    add(1,0,0,  1, MODE_DAY,  1,0, 0);
    add(1,0,0, 16, MODE_DAY,  0,0,16);
    add(1,0,0,  1, MODE_PED,  1,1, 0);  // aborted request re-served
    add(1,0,0, 31, MODE_PED,  0,0,31);
    add(1,0,0,  1, MODE_DAY,  1,0, 0);
    add(1,0,0, 50, MODE_DAY,  0,0,50);
    add(0,0,0,  3, MODE_DAY,  0,0,53);  // DEBOUNCE-1 samples: rejected
    add(1,0,0,  1, MODE_DAY,  0,0,54);
    add(0,0,0,  4, MODE_DAY,  0,0,58);  // accepted at 4th sample
    add(0,0,0,  1, MODE_NIGHT,1,0, 0);
    add(0,0,0,255, MODE_NIGHT,0,0,255); // saturation
    add(0,0,0,  1, MODE_NIGHT,0,0,255);
    add(0,0,1,  1, MODE_EMG,  1,0, 0);
    add(0,0,0,  3, MODE_EMG,  0,0, 3);
    add(0,0,1,  1, MODE_EMG,  0,0, 4);  // reassert: no modeChanged
    add(0,0,0,  8, MODE_EMG,  0,0,12);  // counter was reloaded
    add(0,0,0,  1, MODE_NIGHT,1,0, 0);
    add(0,1,1,  1, MODE_EMG,  1,0, 0);  // simultaneous ped+emg
    add(0,0,0,  9, MODE_NIGHT,1,0, 0);  // exit never to PED
    add(0,0,0, 16, MODE_NIGHT,0,0,16);
    add(0,0,0,  1, MODE_PED,  1,1, 0);
    add(0,0,0, 31, MODE_PED,  0,0,31);
    add(0,0,0,  1, MODE_NIGHT,1,0, 0);  // PED exits to NIGHT

    rst = 1'b1;
    bus.timeSignal = 1'b1;
    bus.pedSignal  = 1'b0;
    bus.emgSignal  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", MODE_NIGHT, 1'b0, 1'b0, 0);
    $display("reset: state=%0d dwell=%0d", bus.currentState, bus.dwellCount);
    rst = 1'b0;

    foreach (vecs[i]) begin
      bus.timeSignal = vecs[i].t;
      bus.pedSignal  = vecs[i].p;
      bus.emgSignal  = vecs[i].e;
      repeat (vecs[i].n) @(posedge clk);
      @(negedge clk);
      $display("vec %0d: t=%0b p=%0b e=%0b n=%0d -> state=%0d mc=%0b ack=%0b dwell=%0d",
               i, vecs[i].t, vecs[i].p, vecs[i].e, vecs[i].n,
               bus.currentState, bus.modeChanged, bus.pedAck, bus.dwellCount);
      check_outputs($sformatf("vec%0d", i), vecs[i].st, vecs[i].mc,
                    vecs[i].ack, vecs[i].dw);
    end

    // Mid-PED asynchronous reset with a request pending.
    bus.pedSignal = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.pedSignal = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("rstseq.in_ped", int'(bus.currentState), int'(MODE_PED));
    bus.pedSignal = 1'b1;  // queue another crossing while in PED
    @(posedge clk);
    @(negedge clk);
    bus.pedSignal = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rstseq.pre_dwell", int'(bus.dwellCount), 5);
    #2 rst = 1'b1;
    #1;
    $display("rstseq: async reset -> state=%0d dwell=%0d", bus.currentState, bus.dwellCount);
    check_outputs("rstseq.async", MODE_NIGHT, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
    ack_seen = 0;
    for (int k = 0; k < 17; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.pedAck) ack_seen++;
    end
    $display("rstseq: after release state=%0d dwell=%0d acks=%0d",
             bus.currentState, bus.dwellCount, ack_seen);
    check("rstseq.no_ack", ack_seen, 0);
    check("rstseq.state", int'(bus.currentState), int'(MODE_NIGHT));
    check("rstseq.dwell", int'(bus.dwellCount), 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
